// File: rtl/fme_serializador_saida_if.sv
// FME result capture bus and 4-sample beat stream toward the consumer.
// master drives done/amostras/dado_pronto; slave is the serializer side.
interface fme_serializador_saida_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_AMOSTRAS      = 162,
  parameter int AMOSTRAS_POR_BEAT = 4
);
  logic                                  done;
  logic [NUM_AMOSTRAS*DATA_WIDTH-1:0]      amostras;
  logic [AMOSTRAS_POR_BEAT*DATA_WIDTH-1:0] dado;
  logic                                  dado_valido;
  logic                                  dado_pronto;
  logic [2:0]                            dado_qtd;
  logic                                  dado_ultimo;
  logic                                  ocupado;
  logic                                  sobreposicao;

  modport master (
    output done, amostras, dado_pronto,
    input  dado, dado_valido, dado_qtd, dado_ultimo, ocupado, sobreposicao
  );

  modport slave (
    input  done, amostras, dado_pronto,
    output dado, dado_valido, dado_qtd, dado_ultimo, ocupado, sobreposicao
  );
endinterface

// File: rtl/fme_serializador_saida.sv
// Captures all FME samples on the rising edge of done and streams them as 4-sample beats:
// first beat valid one cycle after capture, one beat per cycle; beats hold stable while dado_pronto is low.
module fme_serializador_saida #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_AMOSTRAS      = 162,
  parameter int AMOSTRAS_POR_BEAT = 4
) (
  input logic                       clock,
  input logic                       reset,
  fme_serializador_saida_if.slave   bus
);
  localparam int BW        = AMOSTRAS_POR_BEAT * DATA_WIDTH;
  localparam int NUM_BEATS = (NUM_AMOSTRAS + AMOSTRAS_POR_BEAT - 1) / AMOSTRAS_POR_BEAT;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int RESTO     = NUM_AMOSTRAS % AMOSTRAS_POR_BEAT;

  localparam logic [2:0]        QTD_CHEIO   = 3'(AMOSTRAS_POR_BEAT);
  localparam logic [2:0]        QTD_ULTIMO  = (RESTO == 0) ? 3'(AMOSTRAS_POR_BEAT) : 3'(RESTO);
  localparam logic [BEAT_W-1:0] ULTIMO_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic {OCIOSO, ENVIO} estado_t;

  estado_t                      r_estado;
  estado_t                      w_prox;
  logic                         r_done_d;
  logic                         r_sobre;
  logic [BEAT_W-1:0]            r_beat;
  logic [BEAT_W-1:0]            w_beat_prox;
  logic [NUM_BEATS-1:0][BW-1:0] r_banco;
  logic [NUM_BEATS*BW-1:0]      w_pad;
  logic                         w_captura;
  logic                         w_carrega;
  logic                         w_handshake;
  logic                         w_ultimo;
  logic [BW-1:0]                w_dado;
  logic [2:0]                   w_qtd;

  assign w_captura   = bus.done & ~r_done_d;
  assign w_handshake = (r_estado == ENVIO) & bus.dado_pronto;
  assign w_ultimo    = (r_beat == ULTIMO_BEAT);

  // Bank is stored beat-aligned; lanes past the last sample stay zero.
  always_comb begin
    w_pad = '0;
    w_pad[NUM_AMOSTRAS*DATA_WIDTH-1:0] = bus.amostras;
  end

  always_comb begin
    w_prox      = r_estado;
    w_beat_prox = r_beat;
    w_carrega   = 1'b0;
    w_dado      = '0;
    w_qtd       = '0;
    unique case (r_estado)
      OCIOSO: begin
        if (w_captura) begin
          w_prox      = ENVIO;
          w_beat_prox = '0;
          w_carrega   = 1'b1;
        end
      end
      ENVIO: begin
        w_dado = r_banco[r_beat];
        w_qtd  = w_ultimo ? QTD_ULTIMO : QTD_CHEIO;
        if (w_handshake) begin
          if (w_ultimo) w_prox      = OCIOSO;
          else          w_beat_prox = r_beat + BEAT_W'(1);
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_done_d <= 1'b0;
      r_beat   <= '0;
      r_banco  <= '0;
      r_sobre  <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_done_d <= bus.done;
      r_beat   <= w_beat_prox;
      if (w_carrega) r_banco <= w_pad;
      // A new result arriving mid-stream is dropped, only flagged.
      if (w_captura && (r_estado == ENVIO)) r_sobre <= 1'b1;
    end
  end

  assign bus.dado         = w_dado;
  assign bus.dado_qtd     = w_qtd;
  assign bus.dado_valido  = (r_estado == ENVIO);
  assign bus.ocupado      = (r_estado == ENVIO);
  assign bus.dado_ultimo  = (r_estado == ENVIO) & w_ultimo;
  assign bus.sobreposicao = r_sobre;
endmodule

// File: tb/tb_fme_serializador_saida.sv
// Directed + randomized bench for fme_serializador_saida against a sample-array reference model.
module tb_fme_serializador_saida;
  localparam int DW = 8;
  localparam int N  = 162;
  localparam int A  = 4;
  localparam int NB = (N + A - 1) / A;
  localparam int BW = A * DW;

  logic clock = 1'b0;
  logic reset;

  fme_serializador_saida_if #(.DATA_WIDTH(DW), .NUM_AMOSTRAS(N), .AMOSTRAS_POR_BEAT(A)) u_if ();

  fme_serializador_saida #(.DATA_WIDTH(DW), .NUM_AMOSTRAS(N), .AMOSTRAS_POR_BEAT(A)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0]    samp     [N];
  logic [BW-1:0] exp_dado [NB];
  logic [2:0]    exp_qtd  [NB];
  logic          exp_ult  [NB];
  logic          sobre_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Beat b = samples 4b..4b+3, lane 0 first, zero beyond the last sample.
  function automatic void build_model();
    for (int b = 0; b < NB; b++) begin
      int rem;
      rem         = N - b * A;
      exp_qtd[b]  = 3'((rem >= A) ? A : rem);
      exp_ult[b]  = (b == NB - 1);
      exp_dado[b] = '0;
      for (int j = 0; j < A; j++)
        if (b * A + j < N) exp_dado[b] |= BW'(samp[b * A + j]) << (j * DW);
    end
  endfunction

  // modo 0: sample k = k, 1: all 8'hFF, 2: random
  task automatic set_amostras(input int modo, input bit upd);
    logic [N*DW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      logic [7:0] s;
      s = (modo == 0) ? 8'(k) : (modo == 1) ? 8'hFF : 8'($urandom);
      v |= (N*DW)'(s) << (k * DW);
      if (upd) samp[k] = s;
    end
    u_if.amostras = v;
    if (upd) build_model();
  endtask

  task automatic pulse_done();
    u_if.done = 1'b1;
    @(negedge clock);
    u_if.done = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valido"},  64'(u_if.dado_valido), 64'(0));
    chk({tag, "_ocupado"}, 64'(u_if.ocupado),     64'(0));
    chk({tag, "_dado"},    64'(u_if.dado),        64'(0));
    chk({tag, "_qtd"},     64'(u_if.dado_qtd),    64'(0));
    chk({tag, "_ultimo"},  64'(u_if.dado_ultimo), 64'(0));
    chk({tag, "_sobre"},   64'(u_if.sobreposicao), 64'(sobre_exp));
  endtask

  // Called at a negedge one cycle after the capture edge; every cycle until
  // the last handshake must present the expected beat with dado_valido high.
  task automatic run_stream(input bit rnd, input int inject_at, input int stop_at);
    int b = 0;
    int ciclos = 0;
    bit pend = 0;
    bit feito = 0;
    while (b < NB && ciclos < 3000) begin
      if (b == stop_at) return;
      if (pend) begin
        sobre_exp = 1'b1;
        u_if.done = 1'b0;
        pend = 0;
      end
      chk($sformatf("valido b%0d", b),  64'(u_if.dado_valido),  64'(1));
      chk($sformatf("ocupado b%0d", b), 64'(u_if.ocupado),      64'(1));
      chk($sformatf("dado b%0d", b),    64'(u_if.dado),         64'(exp_dado[b]));
      chk($sformatf("qtd b%0d", b),     64'(u_if.dado_qtd),     64'(exp_qtd[b]));
      chk($sformatf("ultimo b%0d", b),  64'(u_if.dado_ultimo),  64'(exp_ult[b]));
      chk($sformatf("sobre b%0d", b),   64'(u_if.sobreposicao), 64'(sobre_exp));
      u_if.dado_pronto = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk($sformatf("valido_vs_pronto b%0d", b), 64'(u_if.dado_valido), 64'(1));
      if (b == inject_at && !feito) begin
        u_if.done = 1'b1;
        set_amostras(1, 1'b0);
        pend  = 1;
        feito = 1;
      end
      if (u_if.dado_valido && u_if.dado_pronto) b++;
      @(negedge clock);
      ciclos++;
    end
    if (pend) begin
      sobre_exp = 1'b1;
      u_if.done = 1'b0;
    end
    chk("beats_entregues", 64'(b), 64'(NB));
    chk_idle("pos_stream");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    u_if.done        = 1'b0;
    u_if.dado_pronto = 1'b0;
    u_if.amostras    = '0;
    sobre_exp        = 1'b0;
    #1;
    chk_idle("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("apos_reset");

    // Ramp data, consumer always ready
    set_amostras(0, 1'b1);
    pulse_done();
    run_stream(1'b0, -1, -1);

    // Same data, random stalls
    pulse_done();
    run_stream(1'b1, -1, -1);

    // done held for 100 cycles: one stream only, no overrun
    set_amostras(2, 1'b1);
    u_if.done = 1'b1;
    @(negedge clock);
    run_stream(1'b0, -1, -1);
    for (int i = 0; i < 100 - NB - 1; i++) begin
      @(negedge clock);
      chk("done_alto_sem_recaptura", 64'(u_if.dado_valido), 64'(0));
    end
    chk("done_alto_sobre", 64'(u_if.sobreposicao), 64'(0));
    u_if.done = 1'b0;
    @(negedge clock);

    // Overrun at beat 10: new all-FF result discarded, flag sticky
    set_amostras(2, 1'b1);
    pulse_done();
    run_stream(1'b1, 10, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("sobre_persistente", 64'(u_if.sobreposicao), 64'(1));
    end

    // Reset at beat 20: outputs clear without a clock edge
    set_amostras(0, 1'b1);
    pulse_done();
    run_stream(1'b1, -1, 20);
    #1 reset = 1'b1;
    sobre_exp = 1'b0;
    #1;
    chk_idle("reset_async");
    @(negedge clock);
    reset = 1'b0;
    set_amostras(2, 1'b1);
    pulse_done();
    run_stream(1'b1, -1, -1);

    // done high through reset release: capture on the first edge
    set_amostras(2, 1'b1);
    reset     = 1'b1;
    u_if.done = 1'b1;
    @(negedge clock);
    chk("reset_done_alto_valido", 64'(u_if.dado_valido), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    run_stream(1'b0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("done_alto_pos_reset_ocioso", 64'(u_if.ocupado), 64'(0));
    end
    u_if.done = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fme_serializador_saida.md
# fme_serializador_saida

Output-side reader for the fractional motion estimation (FME) datapath. It captures the 162 interpolated 8-bit samples that the FME core presents in parallel when the core raises `done`. It then streams them to the downstream consumer as 4-sample beats over a valid/ready handshake. It sits directly after the FME top level, so the consumer does not need a 162-wide parallel bus.

## Interface
- `DATA_WIDTH`, 8, width of one sample.
- `NUM_AMOSTRAS`, 162, samples captured per FME result.
- `AMOSTRAS_POR_BEAT`, 4, samples per output beat.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `done`  in  1  FME completion flag.
- `amostras`  in  NUM_AMOSTRAS*DATA_WIDTH  flattened FME outputs; sample k (FME `out_k`) at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `dado`  out  AMOSTRAS_POR_BEAT*DATA_WIDTH  current beat; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- `dado_valido`  out  1  beat valid.
- `dado_pronto`  in  1  consumer ready.
- `dado_qtd`  out  3  number of valid lanes in the beat (1..4).
- `dado_ultimo`  out  1  high on the final beat of a result.
- `ocupado`  out  1  high while a captured result is being streamed.
- `sobreposicao`  out  1  sticky overrun flag.

## Operation
- `done` is registered as `done_d`. `captura = done & ~done_d`, so capture is edge-triggered and tolerates `done` held high.
- FSM states:
  - OCIOSO:
    - On `captura`, load the register bank from `amostras`, clear the beat index to 0, and go to ENVIO.
    - Otherwise stay in OCIOSO.
  - ENVIO:
    - `dado_valido` = 1.
    - On `dado_valido & dado_pronto`:
      - if the beat index = 40, go to OCIOSO;
      - else increment the beat index.
- Beat b carries samples 4b..4b+3, with sample 4b in lane 0.
- Beats 0..39 carry `dado_qtd` = 4.
- Beat 40 carries sample 160 in lane 0 and sample 161 in lane 1. Lanes 2..3 are driven 0, `dado_qtd` = 2 and `dado_ultimo` = 1.
- In general, the beat count is ceil(NUM_AMOSTRAS/AMOSTRAS_POR_BEAT), and the last beat holds NUM_AMOSTRAS mod AMOSTRAS_POR_BEAT lanes (or a full beat if the remainder is 0). Unused lanes are zero.
- `dado`, `dado_qtd` and `dado_ultimo` are decoded from the register bank and the beat index. They are 0 in OCIOSO.
- Handshake rules:
  - `dado_valido` never depends combinationally on `dado_pronto`.
  - While `dado_valido=1` and `dado_pronto=0`, `dado`, `dado_qtd` and `dado_ultimo` hold stable.
- `ocupado` = (state == ENVIO).
- Overrun: if `captura` occurs while in ENVIO, including the cycle of the final handshake:
  - the new `amostras` are discarded;
  - the stream in progress continues unchanged;
  - `sobreposicao` sets to 1 and stays 1 until `reset`.

## Timing
- Reset values:
  - `dado_valido` = 0, `ocupado` = 0, `dado_ultimo` = 0, `dado_qtd` = 0, `dado` = 0, `sobreposicao` = 0;
  - `done_d` = 0, state = OCIOSO, beat index = 0.
- Capture latency: if `done` rises before edge t, the bank is loaded at edge t and `dado_valido` is high in the cycle after t.
- Throughput: one beat per cycle while `dado_pronto`=1. A full result takes 41 cycles, from the first valid cycle through the last handshake.
- After the last handshake edge, `ocupado` and `dado_valido` are low in the next cycle. A `captura` seen in that OCIOSO cycle is accepted normally.
- `done` high when `reset` deasserts: `done_d`=0, so a capture occurs on the first edge after reset release.
- `reset` asserted mid-stream: outputs go to their reset values immediately (asynchronously). The partial result is lost and is not resumed.
- `dado_pronto` may toggle arbitrarily. Beat order and content are unaffected by stalls.

## Test plan
- Load `amostras` with sample k = k, then pulse `done` for 1 cycle with `dado_pronto`=1. Required response:
  - 41 consecutive beats; beat 0 = {3,2,1,0};
  - beat 39 = {159,158,157,156} with `dado_qtd`=4;
  - beat 40 = {0,0,161,160} with `dado_qtd`=2 and `dado_ultimo`=1;
  - `ocupado` low on the following cycle.
- Same data, with `dado_pronto` following a random 50% pattern. Required response: beats are identical in order and content, and `dado`, `dado_qtd` and `dado_ultimo` are stable across every stalled cycle.
- Hold `done` high for 100 cycles. Required response: exactly one 41-beat stream and `sobreposicao`=0.
- Change `amostras` to 8'hFF for every sample and raise `done` again at beat 10 of a stream. Required response: the remaining beats still carry the original values, and `sobreposicao`=1 from the next cycle until `reset`.
- Assert `reset` at beat 20 for 1 cycle. Required response:
  - `dado_valido`, `ocupado` and `dado` drop to 0 without waiting for a clock edge;
  - a new `done` pulse produces a full stream starting from beat 0.
- Keep `done`=1 through reset release. Required response: the capture happens on the first edge after release, and beat 0 is valid on the next cycle.
